// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRLV/SRA/SRAV) for the execute stage.
// Shifts at most step_bits positions per clock; start/ready/done handshake.
module shift_right_seq #(
    parameter int unsigned data_width  = 32,
    parameter int unsigned shamt_width = 5,
    parameter int unsigned step_bits   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_in,
    input  logic [data_width-1:0]  data_in,
    input  logic [shamt_width-1:0] shamt_in,
    input  logic                   arith_in,
    input  logic                   flush_in,
    output logic                   ready_out,
    output logic                   done_out,
    output logic [data_width-1:0]  data_out
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [shamt_width-1:0] StepLim = shamt_width'(step_bits);

    state_e                 state_q, state_d;
    logic [data_width-1:0]  data_q, data_d, shifted;
    logic [shamt_width-1:0] remaining_q, remaining_d, remaining_next, step_k;
    logic                   mode_q, mode_d, msb_q, msb_d, fill;

    // Sign bit is captured at acceptance so the fill never follows data_in mid-shift.
    assign fill = mode_q & msb_q;

    always_comb begin
        step_k  = (remaining_q < StepLim) ? remaining_q : StepLim;
        shifted = data_q;
        for (int i = 0; i < int'(step_bits); i++) begin
            if (shamt_width'(i) < step_k) begin
                shifted = {fill, shifted[data_width-1:1]};
            end
        end
        remaining_next = remaining_q - step_k;
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        msb_d       = msb_q;
        if (flush_in) begin
            state_d     = StIdle;
            data_d      = '0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_in) begin
                        data_d      = data_in;
                        remaining_d = shamt_in;
                        mode_d      = arith_in;
                        msb_d       = data_in[data_width-1];
                        state_d     = (shamt_in == '0) ? StDone : StShift;
                    end
                end
                StShift: begin
                    data_d      = shifted;
                    remaining_d = remaining_next;
                    if (remaining_next == '0) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            msb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            msb_q       <= msb_d;
        end
    end

    assign ready_out = (state_q == StIdle);
    assign done_out  = (state_q == StDone);
    assign data_out  = data_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: step_bits=1 and step_bits=4 instances share stimulus and are
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        reset_n, start_in, arith_in, flush_in;
    logic [31:0] data_in;
    logic [4:0]  shamt_in;
    logic        ready1, done1, ready4, done4;
    logic [31:0] dout1, dout4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_right_seq #(.data_width(32), .shamt_width(5), .step_bits(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_in(start_in), .data_in(data_in),
        .shamt_in(shamt_in), .arith_in(arith_in), .flush_in(flush_in),
        .ready_out(ready1), .done_out(done1), .data_out(dout1)
    );

    shift_right_seq #(.data_width(32), .shamt_width(5), .step_bits(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start_in(start_in), .data_in(data_in),
        .shamt_in(shamt_in), .arith_in(arith_in), .flush_in(flush_in),
        .ready_out(ready4), .done_out(done4), .data_out(dout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
        logic signed [31:0] sd;
        sd = d;
        return a ? 32'(sd >>> s) : (d >> s);
    endfunction

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Transaction model: result from plain arithmetic, timing from ceil(shamt/step).
    logic        m_busy[2];
    logic        m_done[2];
    int          m_left[2];
    logic [31:0] m_res[2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_left[i] <= 0;
                m_res[i]  <= '0;
            end else if (flush_in) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_left[i] <= 0;
                m_res[i]  <= '0;
            end else if (!m_busy[i]) begin
                if (start_in) begin
                    m_busy[i] <= 1'b1;
                    m_res[i]  <= ref_shift(data_in, int'(shamt_in), arith_in);
                    m_left[i] <= (int'(shamt_in) + step_of(i) - 1) / step_of(i);
                    m_done[i] <= (shamt_in == 5'd0);
                end
            end else if (m_done[i]) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end else begin
                m_left[i] <= m_left[i] - 1;
                m_done[i] <= (m_left[i] == 1);
            end
        end
    end

    logic chk_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (chk_en && reset_n) begin
            check("ready1", 32'(ready1), 32'(!m_busy[0]));
            check("done1", 32'(done1), 32'(m_done[0]));
            if (!m_busy[0] || m_done[0]) check("data1", dout1, m_res[0]);
            check("ready4", 32'(ready4), 32'(!m_busy[1]));
            check("done4", 32'(done4), 32'(m_done[1]));
            if (!m_busy[1] || m_done[1]) check("data4", dout4, m_res[1]);
        end
    end

    // Issue one op; alternate operands appear right after acceptance, and start stays high
    // through edge 'hold' to probe start-while-busy.
    task automatic run(input string tag, input logic [31:0] d, input logic [4:0] s,
                       input logic a, input logic [31:0] exp_res, input int exp1,
                       input int exp4, input int hold);
        int lat1 = 0, lat4 = 0, p1 = 0, p4 = 0;
        logic [31:0] r1 = '0, r4 = '0;
        @(negedge clk);
        data_in  = d;
        shamt_in = s;
        arith_in = a;
        start_in = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                data_in  = 32'h0000_0001;
                shamt_in = 5'd1;
                arith_in = ~a;
            end
            if (e >= hold) start_in = 1'b0;
            if (done1) begin p1++; if (lat1 == 0) begin lat1 = e; r1 = dout1; end end
            if (done4) begin p4++; if (lat4 == 0) begin lat4 = e; r4 = dout4; end end
            if (lat1 != 0 && e == lat1 + 1) check({tag, "_ready1_after"}, 32'(ready1), 32'd1);
            if (lat1 != 0 && lat4 != 0 && ready1 && ready4 && e > hold) break;
        end
        start_in = 1'b0;
        check({tag, "_lat1"}, 32'(lat1), 32'(exp1));
        check({tag, "_lat4"}, 32'(lat4), 32'(exp4));
        check({tag, "_res1"}, r1, exp_res);
        check({tag, "_res4"}, r4, exp_res);
        check({tag, "_pulses1"}, 32'(p1), 32'd1);
        check({tag, "_pulses4"}, 32'(p4), 32'd1);
        check({tag, "_held1"}, dout1, exp_res);
    endtask

    task automatic count_done(input string tag, input int n);
        int p = 0;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            if (done1 || done4) p++;
        end
        check({tag, "_no_done"}, 32'(p), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start_in = 1'b0;
        arith_in = 1'b0;
        flush_in = 1'b0;
        data_in  = '0;
        shamt_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_data1", dout1, 32'd0);
        check("rst_ready4", 32'(ready4), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run("srl4",    32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 5,  2, 1);
        run("sra4n",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 5,  2, 1);
        run("sra4p",   32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF, 5,  2, 1);
        run("zero",    32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1,  1, 1);
        run("sra31",   32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, 9, 1);
        run("srl31",   32'hF0F0_F0F0, 5'd31, 1'b0, 32'h0000_0001, 32, 9, 1);
        run("sra7",    32'hA5A5_A5A5, 5'd7,  1'b1, 32'hFF4B_4B4B, 8,  3, 1);
        run("busy",    32'h1234_5678, 5'd10, 1'b0, 32'h0004_8D15, 11, 4, 5);

        // flush beats start in IDLE
        @(negedge clk);
        data_in  = 32'h5555_5555;
        shamt_in = 5'd3;
        start_in = 1'b1;
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        flush_in = 1'b0;
        check("flstart_ready1", 32'(ready1), 32'd1);
        check("flstart_ready4", 32'(ready4), 32'd1);
        check("flstart_data1", dout1, 32'd0);

        // flush mid-shift
        @(negedge clk);
        data_in  = 32'hFFFF_0000;
        shamt_in = 5'd20;
        arith_in = 1'b0;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        @(posedge clk);
        #1;
        check("flmid_busy1", 32'(ready1), 32'd0);
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        check("flmid_ready1", 32'(ready1), 32'd1);
        check("flmid_ready4", 32'(ready4), 32'd1);
        check("flmid_data1", dout1, 32'd0);
        check("flmid_data4", dout4, 32'd0);
        count_done("flmid", 30);

        // async reset mid-shift, low for half a cycle between edges
        @(negedge clk);
        data_in  = 32'hCAFE_F00D;
        shamt_in = 5'd20;
        arith_in = 1'b1;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("ar_busy4", 32'(ready4), 32'd0);
        reset_n = 1'b0;
        #1;
        check("ar_data1", dout1, 32'd0);
        check("ar_data4", dout4, 32'd0);
        check("ar_ready1", 32'(ready1), 32'd1);
        check("ar_ready4", 32'(ready4), 32'd1);
        check("ar_done1", 32'(done1 | done4), 32'd0);
        #4;
        reset_n = 1'b1;
        count_done("ar", 30);

        run("after",   32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765, 17, 5, 1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
